// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Runtime-programmable oversample / baud tick generator for the UART path.
// The system clock is divided by a fixed-point divisor made of an integer
// terminal count (tc) and a fractional part (frac, units of 1/2^FRAC_W cycle).
// Each period lasts tc + 1 + carry cycles. carry comes from a fractional
// accumulator, so the long-run average period is tc + 1 + frac/2^FRAC_W with
// no drift.
//
// Ports
//   clk50      in   system clock (single domain)
//   rst_n      in   synchronous active-low reset
//   en         in   run enable; 0 holds the generator idle with outputs low
//   cfg_wr     in   one-cycle write strobe for a new divisor
//   cfg_tc     in   new terminal count  [DIV_W]
//   cfg_frac   in   new fractional part [FRAC_W]
//   cfg_pend   out  a written divisor has not been applied yet
//   os_tick    out  one-cycle oversample enable
//   baud_tick  out  one-cycle baud enable, with every OVERSAMPLE-th os_tick
//   os_idx     out  os_tick count modulo OVERSAMPLE [IDX_W]
//   clkout     out  legacy ~50% duty square wave, one cycle per os_tick period
//
// Limitation: with tc = 2^DIV_W-1 and frac != 0, the long period needs a
// count of 2^DIV_W, which cnt cannot hold. Keep tc <= 2^DIV_W-2 when using
// a fractional divisor.
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_TC   = 324,
    parameter int DEFAULT_FRAC = 8,
    parameter int IDX_W        = $clog2(OVERSAMPLE)
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [DIV_W-1:0]  cfg_tc,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_pend,
    output logic              os_tick,
    output logic              baud_tick,
    output logic [IDX_W-1:0]  os_idx,
    output logic              clkout
);

    // Active divisor and the shadow holding a written-but-unapplied divisor.
    logic [DIV_W-1:0]  r_tc;
    logic [FRAC_W-1:0] r_frac;
    logic [DIV_W-1:0]  r_sh_tc;
    logic [FRAC_W-1:0] r_sh_frac;

    // Period counter and fractional accumulator.
    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;

    // Registered outputs.
    logic [IDX_W-1:0]  r_idx;
    logic              r_os;
    logic              r_baud;
    logic              r_clk;
    logic              r_pend;

    logic [DIV_W:0]    w_term_cnt;
    logic              w_terminal;
    logic              w_half;
    logic [FRAC_W:0]   w_acc_sum;
    logic              w_idx_last;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_apply_run;
    logic              w_apply_idle;

    // Terminal count of the current period includes the carry earned at the
    // previous boundary; compared one bit wider so tc+1 never wraps.
    assign w_term_cnt = {1'b0, r_tc} + {{DIV_W{1'b0}}, r_carry};
    assign w_terminal = ({1'b0, r_cnt} == w_term_cnt);
    assign w_half     = (r_cnt == (r_tc >> 1));
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_frac};

    assign w_idx_last = (r_idx == IDX_W'(OVERSAMPLE - 1));
    assign w_idx_next = w_idx_last ? '0 : r_idx + IDX_W'(1);

    // Config handshake: cfg_wr is a fire-and-forget strobe (no ready); every
    // strobe overwrites the shadow and raises cfg_pend on the next cycle.
    // The shadow is applied at a period boundary while running, or on any
    // idle cycle while en=0. A strobe landing on the applying cycle defers
    // the apply by one opportunity so the freshly written value is the one
    // that gets used, never the value it just replaced.
    assign w_apply_run  = en  && w_terminal && r_pend && !cfg_wr;
    assign w_apply_idle = !en && r_pend && !cfg_wr;

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            r_tc      <= DIV_W'(DEFAULT_TC);
            r_frac    <= FRAC_W'(DEFAULT_FRAC);
            r_sh_tc   <= '0;
            r_sh_frac <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_os      <= 1'b0;
            r_baud    <= 1'b0;
            r_clk     <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (cfg_wr) begin
                r_sh_tc   <= cfg_tc;
                r_sh_frac <= cfg_frac;
                r_pend    <= 1'b1;
            end

            if (!en) begin
                // Idle: everything parked at the start of a fresh period so
                // re-enabling gives a full period before the first tick.
                r_cnt   <= '0;
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_idx   <= '0;
                r_os    <= 1'b0;
                r_baud  <= 1'b0;
                r_clk   <= 1'b0;
                if (w_apply_idle) begin
                    r_tc   <= r_sh_tc;
                    r_frac <= r_sh_frac;
                    r_pend <= 1'b0;
                end
            end else if (w_terminal) begin
                // Boundary event. Clearing clkout here also covers tc=0,
                // where the half-point and the boundary coincide.
                r_cnt  <= '0;
                r_os   <= 1'b1;
                r_baud <= w_idx_last;
                r_idx  <= w_idx_next;
                r_clk  <= 1'b0;
                if (w_apply_run) begin
                    r_tc    <= r_sh_tc;
                    r_frac  <= r_sh_frac;
                    r_acc   <= '0;
                    r_carry <= 1'b0;
                    r_pend  <= 1'b0;
                end else begin
                    {r_carry, r_acc} <= w_acc_sum;
                end
            end else begin
                r_cnt  <= r_cnt + DIV_W'(1);
                r_os   <= 1'b0;
                r_baud <= 1'b0;
                if (w_half) begin
                    r_clk <= 1'b1;
                end
            end
        end
    end

    assign cfg_pend  = r_pend;
    assign os_tick   = r_os;
    assign baud_tick = r_baud;
    assign os_idx    = r_idx;
    assign clkout    = r_clk;

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Directed bench for uart_baud_gen with default parameters (tc=324, frac=8,
// OVERSAMPLE=16). Inputs are driven and outputs sampled on the falling edge;
// "cycle N" counts falling edges from the first cycle with rst_n=1, en=1.
// Expected os_tick cycles are hand-derived: with the default divisor the
// n-th tick lands on cycle n*325 + (n-1)/2.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int IDX_W  = 4;

    logic              clk50 = 1'b0;
    logic              rst_n;
    logic              en;
    logic              cfg_wr;
    logic [DIV_W-1:0]  cfg_tc;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_pend;
    logic              os_tick;
    logic              baud_tick;
    logic [IDX_W-1:0]  os_idx;
    logic              clkout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk50 = ~clk50;

    uart_baud_gen dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_wr    (cfg_wr),
        .cfg_tc    (cfg_tc),
        .cfg_frac  (cfg_frac),
        .cfg_pend  (cfg_pend),
        .os_tick   (os_tick),
        .baud_tick (baud_tick),
        .os_idx    (os_idx),
        .clkout    (clkout)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk50);
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        cfg_wr   = 1'b0;
        cfg_tc   = '0;
        cfg_frac = '0;
        step();
        step();
    endtask

    task automatic release_run();
        rst_n = 1'b1;
        en    = 1'b1;
        cyc   = 0;
    endtask

    task automatic write_cfg(input int tc, input int frac);
        cfg_wr   = 1'b1;
        cfg_tc   = DIV_W'(tc);
        cfg_frac = FRAC_W'(frac);
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic wait_os(input int limit, output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            step();
            n++;
        end while (os_tick !== 1'b1 && n < limit);
        if (os_tick === 1'b1) at = cyc;
        else check("os_tick_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int at;
        int baud16;
        int baud32;
        baud16 = 0;
        baud32 = 0;

        // Reset state
        do_reset();
        check("rst_os_tick", os_tick, 0);
        check("rst_baud_tick", baud_tick, 0);
        check("rst_os_idx", os_idx, 0);
        check("rst_clkout", clkout, 0);
        check("rst_cfg_pend", cfg_pend, 0);

        // Default divisor: first tick, clkout half point, 32 ticks
        release_run();
        check("c0_os_tick", os_tick, 0);
        step_to(162);
        check("clkout_before_half", clkout, 0);
        step_to(163);
        check("clkout_after_half", clkout, 1);
        step_to(324);
        check("pre_tick_os", os_tick, 0);
        check("pre_tick_clkout", clkout, 1);

        for (int n = 1; n <= 32; n++) exp_q.push_back(32'(n * 325 + (n - 1) / 2));
        for (int n = 1; n <= 32; n++) begin
            wait_os(400, at);
            check("def_tick_cycle", at, exp_q.pop_front());
            check("def_os_idx", os_idx, n % 16);
            check("def_baud_tick", baud_tick, (n % 16 == 0) ? 1 : 0);
            if (n == 1) check("clkout_cleared", clkout, 0);
            if (n == 16) baud16 = at;
            if (n == 32) baud32 = at;
        end
        check("baud_period", baud32 - baud16, 5208);
        step();
        check("baud_one_cycle", baud_tick, 0);

        // Reload while running: old period completes, then period 10
        do_reset();
        release_run();
        step_to(100);
        check("pend_before_wr", cfg_pend, 0);
        write_cfg(9, 0);
        check("pend_after_wr", cfg_pend, 1);
        step_to(324);
        check("pend_held", cfg_pend, 1);
        wait_os(400, at);
        check("reload_old_period", at, 325);
        step_to(326);
        check("pend_cleared", cfg_pend, 0);
        wait_os(40, at);
        check("reload_tick2", at, 335);
        wait_os(40, at);
        check("reload_tick3", at, 345);

        // Overwrites while pending, last one coincident with boundary at 354
        step_to(348);
        write_cfg(4, 0);
        check("pend_ow1", cfg_pend, 1);
        step_to(350);
        write_cfg(7, 0);
        step_to(354);
        write_cfg(7, 0);
        check("coinc_tick", os_tick, 1);
        check("coinc_pend", cfg_pend, 1);
        wait_os(40, at);
        check("coinc_not_applied", at, 365);
        step_to(366);
        check("coinc_pend_clear", cfg_pend, 0);
        wait_os(40, at);
        check("tc7_tick1", at, 373);
        wait_os(40, at);
        check("tc7_tick2", at, 381);

        // tc=0, frac=0 loaded while idle
        en       = 1'b0;
        cfg_wr   = 1'b1;
        cfg_tc   = '0;
        cfg_frac = '0;
        step();
        cfg_wr = 1'b0;
        check("idle_pend_set", cfg_pend, 1);
        check("idle_os_tick", os_tick, 0);
        check("idle_clkout", clkout, 0);
        step();
        check("idle_pend_clear", cfg_pend, 0);
        en  = 1'b1;
        cyc = 0;
        check("tc0_c0_os", os_tick, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            check("tc0_os_tick", os_tick, 1);
            check("tc0_clkout", clkout, 0);
            check("tc0_baud", baud_tick, (k % 16 == 0) ? 1 : 0);
            check("tc0_os_idx", os_idx, k % 16);
        end

        // Reset mid-period with a pending config
        do_reset();
        release_run();
        step_to(150);
        write_cfg(9, 0);
        step_to(199);
        check("mid_pend", cfg_pend, 1);
        step_to(200);
        check("mid_clkout", clkout, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_os", os_tick, 0);
        check("mid_rst_baud", baud_tick, 0);
        check("mid_rst_idx", os_idx, 0);
        check("mid_rst_clkout", clkout, 0);
        check("mid_rst_pend", cfg_pend, 0);
        rst_n = 1'b1;
        cyc   = 0;
        step_to(324);
        check("mid_pre_tick", os_tick, 0);
        wait_os(400, at);
        check("mid_tick1", at, 325);
        wait_os(400, at);
        check("mid_tick2", at, 650);
        wait_os(400, at);
        check("mid_tick3", at, 976);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
